// File: rtl/mdu_seq.sv
// mdu_seq: iterative radix-2 multiply/divide sequencer owning the MIPS HI/LO pair.
// Define MDU_DIV_EN to build div/divu; without it only mult/multu/mthi/mtlo exist.
module mdu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [5:0]       Funct,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, step_mul, prod;
   logic [WIDTH-1:0] opd_q, opd_d, hi_q, hi_d, lo_q, lo_d, a_mag, b_mag;
   logic [WIDTH:0] add;
   logic neg_q, neg_d, a_neg, b_neg, sgn, is_mul, done_q;
`ifdef MDU_DIV_EN
   logic div_q, div_d, rneg_q, rneg_d, is_div;
   logic [WIDTH:0] sub;
   logic [2*WIDTH-1:0] step_div;
   logic [WIDTH-1:0] quo, rem;
`endif
   assign sgn    = ~Funct[0];
   assign a_neg  = sgn & OpA[WIDTH-1];
   assign b_neg  = sgn & OpB[WIDTH-1];
   assign a_mag  = a_neg ? -OpA : OpA;
   assign b_mag  = b_neg ? -OpB : OpB;
   assign is_mul = Funct[5:1] == 5'b01100;
   // acc holds {partial product, remaining multiplier bits}; opd_q is the multiplicand
   assign add      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
   assign step_mul = acc_q[0] ? {add, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
   assign prod     = neg_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
   assign is_div   = Funct[5:1] == 5'b01101;
   // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
   assign sub      = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opd_q};
   assign step_div = sub[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} : {sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
   assign quo      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem      = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
`ifdef MDU_DIV_EN
      div_d   = div_q;
      rneg_d  = rneg_q;
`endif
      case (state_q)
         IDLE: if (Start) begin
            if (Funct == 6'b010001) hi_d = OpA;
            if (Funct == 6'b010011) lo_d = OpA;
            if (is_mul) begin
               acc_d   = {{WIDTH{1'b0}}, b_mag};
               opd_d   = a_mag;
               neg_d   = a_neg ^ b_neg;
               cnt_d   = '0;
               state_d = CALC;
`ifdef MDU_DIV_EN
               div_d   = 1'b0;
`endif
            end
`ifdef MDU_DIV_EN
            if (is_div) begin
               rneg_d = 1'b0;
               if (OpB == '0) begin
                  // divide by zero reuses the product write-back path with no negation
                  acc_d   = {OpA, {WIDTH{1'b1}}};
                  neg_d   = 1'b0;
                  div_d   = 1'b0;
                  state_d = FIX;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  opd_d   = b_mag;
                  neg_d   = a_neg ^ b_neg;
                  rneg_d  = a_neg;
                  div_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = CALC;
               end
            end
`endif
         end
         CALC: begin
`ifdef MDU_DIV_EN
            acc_d = div_q ? step_div : step_mul;
`else
            acc_d = step_mul;
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
`ifdef MDU_DIV_EN
            {hi_d, lo_d} = div_q ? {rem, quo} : prod;
`else
            {hi_d, lo_d} = prod;
`endif
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
`ifdef MDU_DIV_EN
         div_q   <= 1'b0;
         rneg_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= state_q == FIX;
`ifdef MDU_DIV_EN
         div_q   <= div_d;
         rneg_q  <= rneg_d;
`endif
      end
   end
   assign Busy = state_q != IDLE;
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer owning the HI/LO register pair for the MIPS pipeline. It accepts mult/multu/div/divu/mthi/mtlo from the EX stage. It runs a radix-2 shift-add or shift-subtract datapath over 32 cycles and signals busy so the hazard unit stalls dependent mfhi/mflo and further MDU ops. Signed operations are performed on magnitudes with a final sign-fix cycle.

## Interface
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- Start  input  1  EX-stage issue strobe, qualified by Funct.
- Funct  input  6  mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011. Other codes are ignored.
- OpA  input  WIDTH  rs value (multiplicand or dividend; mthi/mtlo source).
- OpB  input  WIDTH  rt value (multiplier or divisor).
- Busy  output  1  high while state != IDLE.
- Done  output  1  one-cycle pulse in the cycle after HI/LO are written by mult/div.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

## Operation
- States:
  - IDLE: the only state that accepts Start.
  - CALC: WIDTH iterations; a 5-bit counter runs 0..WIDTH-1.
  - FIX: applies the sign correction and writes Hi/Lo.
- Transitions:
  - IDLE -> CALC on Start with a mult/div Funct.
  - IDLE -> FIX on Start with div/divu and OpB==0.
  - CALC -> FIX when counter==WIDTH-1.
  - FIX -> IDLE unconditionally.
- Start while Busy is ignored entirely; operands are latched only on acceptance.
- mthi/mtlo in IDLE write Hi/Lo at the same edge with no Busy. Any Funct outside the six listed leaves all state unchanged.
- Signed flag = ~Funct[0] for mult/div. Operand magnitudes are latched at acceptance; the most-negative value keeps 0x80000000 as an unsigned magnitude.
- mult:
  - Each CALC step conditionally adds the multiplicand to the upper half of the 2*WIDTH accumulator, then shifts right 1.
  - FIX negates the 64-bit product when signed and sign(A)^sign(B).
  - Result: Hi = product[63:32], Lo = product[31:0].
- div:
  - Restoring division, one quotient bit per step.
  - FIX: quotient is negated if signed and sign(A)^sign(B); remainder is negated if signed and sign(A).
  - Result: Lo = quotient, Hi = remainder.
  - 0x80000000 / -1 (signed) gives Lo = 0x80000000, Hi = 0.
- Divide by zero: FIX writes Hi = OpA (as latched), Lo = 0xFFFFFFFF.
- Reset, including mid-CALC or mid-FIX: state IDLE, counter 0, Hi = 0, Lo = 0, Busy = 0, Done = 0 after the edge. Any in-flight operation is discarded.

## Timing
- The accepting edge is E0.
- Normal mult/div:
  - Busy is high for the cycles after E0 through E33.
  - Hi/Lo update at E33 (FIX).
  - Done is high for the cycle after E33, and Busy is 0 in that same cycle.
- Divide by zero: Hi/Lo update at E1; Done is high for the cycle after E1.
- A back-to-back Start is accepted in the Done cycle, since the state is IDLE then.
- Busy and Done are registered outputs; there is no combinational path from Start to Busy.
- Hi/Lo change only at FIX or at an mthi/mtlo edge.

## Configuration
- MDU_DIV_EN defined: div/divu are supported as above.
- MDU_DIV_EN undefined:
  - div/divu Funct codes are treated as unsupported: no acceptance, Busy stays 0, Hi/Lo are unchanged.
  - Restoring-divide logic and the divide-by-zero path are not synthesized.
  - mult, multu, mthi and mtlo are unaffected.

## Test plan
- Reset, then mult with OpA = 7, OpB = 0xFFFFFFFD -> Busy high for 33 cycles; Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB; one-cycle Done.
- multu 0xFFFFFFFF * 0xFFFFFFFF -> Hi = 0xFFFFFFFE, Lo = 0x00000001; Start pulsed during Busy is ignored and the result is unchanged.
- div 0xFFFFFFF9 / 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; divu 100 / 7 -> Lo = 14, Hi = 2; div 0x80000000 / 0xFFFFFFFF -> Lo = 0x80000000, Hi = 0.
- div 0x1234 / 0 -> Done in the cycle after E1; Hi = 0x1234, Lo = 0xFFFFFFFF.
- mthi 0xA5A5A5A5 in IDLE -> Hi updates at the next edge with Busy = 0. Then issue mult and assert reset at iteration 10 -> Busy = 0, Hi = Lo = 0, no Done.
- Build without MDU_DIV_EN: Start with div -> Busy stays 0, Hi/Lo are unchanged, and mult still produces correct results.
